// File: rtl/cpu_pkg.sv
// Constants and types shared between the IF stage and the ID-stage control unit.
package cpu_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JR  = 2'b10;
    localparam logic [1:0] PC_J   = 2'b11;

    localparam logic [WORD_W-1:0] NOP_INST = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] dpc4;
        logic [WORD_W-1:0] inst;
    } if_id_t;

    function automatic logic [WORD_W-1:0] pc_plus4(input logic [WORD_W-1:0] p);
        return p + WORD_W'(4);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched word, or takes a bubble, or holds.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RST_INST = NOP_INST
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   i_load,
    input  logic   i_bubble,
    input  if_id_t i_d,
    output if_id_t o_q
);

    if_id_t r_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= '{dpc4: '0, inst: RST_INST};
        end else if (i_load) begin
            r_q <= i_d;
        end else if (i_bubble) begin
            r_q <= '{dpc4: '0, inst: RST_INST};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, next-PC select, imem handshake, hold buffer,
// pending-redirect latch and the IF/ID register.
module if_stage #(
    parameter logic [cpu_pkg::WORD_W-1:0] RESET_PC = '0,
    parameter logic [cpu_pkg::WORD_W-1:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [1:0]                  pcsource,
    input  logic                        wpcir,
    input  logic [cpu_pkg::WORD_W-1:0]  bpc,
    input  logic [cpu_pkg::WORD_W-1:0]  da,
    input  logic [cpu_pkg::WORD_W-1:0]  jpc,
    output logic                        imem_req,
    output logic [cpu_pkg::WORD_W-1:0]  imem_addr,
    input  logic                        imem_ready,
    input  logic [cpu_pkg::WORD_W-1:0]  imem_rdata,
    output logic [cpu_pkg::WORD_W-1:0]  pc,
    output logic [cpu_pkg::WORD_W-1:0]  dpc4,
    output logic [cpu_pkg::WORD_W-1:0]  inst,
    output logic                        if_busy
);
    import cpu_pkg::*;

    logic [WORD_W-1:0] r_pc;
    logic              r_hold_valid;
    logic [WORD_W-1:0] r_hold_inst;
    logic              r_redir_valid;
    logic [WORD_W-1:0] r_redir_pc;

    logic              w_fetch_done;
    logic [WORD_W-1:0] w_fetched;
    logic              w_redirect;
    logic [WORD_W-1:0] w_target;
    logic [WORD_W-1:0] w_next_pc;
    if_id_t            w_ifid_d;
    if_id_t            w_ifid_q;

    assign imem_req     = !reset && !r_hold_valid;
    assign imem_addr    = r_pc;
    assign pc           = r_pc;
    assign if_busy      = imem_req && !imem_ready;
    assign w_fetch_done = r_hold_valid || (imem_req && imem_ready);
    assign w_fetched    = r_hold_valid ? r_hold_inst : imem_rdata;
    assign w_redirect   = (pcsource != PC_SEQ);

    always_comb begin
        w_target = bpc;
        case (pcsource)
            PC_JR:   w_target = da;
            PC_J:    w_target = jpc;
            default: w_target = bpc;
        endcase
    end

    // A fresh redirect wins; otherwise replay the one latched behind the delay slot.
    always_comb begin
        w_next_pc = pc_plus4(r_pc);
        if (w_redirect) begin
            w_next_pc = w_target;
        end else if (r_redir_valid) begin
            w_next_pc = r_redir_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_hold_valid  <= 1'b0;
            r_hold_inst   <= '0;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= '0;
        end else if (w_fetch_done) begin
            if (wpcir) begin
                r_pc          <= w_next_pc;
                r_hold_valid  <= 1'b0;
                r_redir_valid <= 1'b0;
            end else if (!r_hold_valid) begin
                r_hold_valid <= 1'b1;
                r_hold_inst  <= imem_rdata;
            end
        end else if (wpcir && w_redirect && !r_redir_valid) begin
            r_redir_valid <= 1'b1;
            r_redir_pc    <= w_target;
        end
    end

    assign w_ifid_d = '{dpc4: pc_plus4(r_pc), inst: w_fetched};

    if_id_reg #(
        .RST_INST (NOP_INST)
    ) u_if_id_reg (
        .clock    (clock),
        .reset    (reset),
        .i_load   (w_fetch_done && wpcir),
        .i_bubble (!w_fetch_done && wpcir),
        .i_d      (w_ifid_d),
        .o_q      (w_ifid_q)
    );

    assign dpc4 = w_ifid_q.dpc4;
    assign inst = w_ifid_q.inst;

endmodule
